// File: rtl/bus_arbiter.sv
// bus_arbiter: four-requester round-robin bus arbiter with a hold-time
// limit, a one-cycle turnaround between owners and a sticky timeout flag.
// Requesters: 0 = instruction controller, 1 = IN port, 2 = OUT port, 3 = loader.
module bus_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    input  logic       err_clr,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       tmo_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_TURN = 2'd2;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [1:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;
    logic       tmo_q, tmo_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;

    logic       found;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       rel;
    logic       tmo_hit;
    logic       set_tmo;

    // Round-robin search: first active request at or above ptr, modulo 4.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // FSM next-state and output-register next values.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        set_tmo = 1'b0;
        rel     = done[owner_q] | ~req[owner_q];
        tmo_hit = (hold_q == HOLD_LIM);

        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (found) begin
                    state_d = S_OWN;
                    gnt_d   = 4'b0001 << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    hold_d  = 4'd1;
                end
            end
            S_OWN: begin
                // A genuine release in the timeout cycle takes precedence,
                // so the flag is raised only for a timeout-only exit.
                if (rel || tmo_hit) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = owner_q + 2'd1;
                    hold_d  = '0;
                    set_tmo = tmo_hit && !rel;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase

        if (set_tmo) begin
            tmo_d = 1'b1;
        end else if (err_clr) begin
            tmo_d = 1'b0;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign tmo_err = tmo_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenario tasks plus a random one-hot sweep.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic       err_clr;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tmo_err;

    int total;
    int bad;

    bus_arbiter #(.HOLD_MAX(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .err_clr (err_clr),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .tmo_err (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; done = '0; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
        total++;
        if (tmo_err !== 1'b0) begin bad++; $display("FAIL reset_tmo got=%b want=0", tmo_err); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt cyc=%0d got=%b want=0000", i, gnt); end
        end
    endtask

    task automatic test_dropped_req;
        do_reset();
        req = 4'b0001;
        #2;
        req = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL dropped_req got=%b want=0000", gnt); end
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL dropped_req_busy got=%b want=0", busy); end
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt cyc=%0d got=%b want=0001", c, gnt); end
            total++;
            if (busy !== 1'b1 || owner !== 2'd0) begin
                bad++; $display("FAIL single_busy_owner cyc=%0d got=%b/%0d want=1/0", c, busy, owner);
            end
        end
        done = 4'b0001;
        tick();
        done = 4'b0000;
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL single_turn got=%b/%b want=0000/0", gnt, busy);
        end
        total++;
        if (owner !== 2'd0) begin bad++; $display("FAIL single_owner_hold got=%0d want=0", owner); end
        tick();
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL single_idle got=%b want=0000", gnt); end
        tick();
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL single_regrant got=%b want=0001", gnt); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            total++;
            if (gnt !== exp_g || owner !== 2'(k % 4)) begin
                bad++; $display("FAIL rr_grant k=%0d got=%b/%0d want=%b/%0d", k, gnt, owner, exp_g, k % 4);
            end
            done = exp_g;
            tick();
            done = 4'b0000;
            total++;
            if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_turn k=%0d got=%b want=0000", k, gnt); end
            tick();
            total++;
            if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_idle k=%0d got=%b want=0000", k, gnt); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0100) begin bad++; $display("FAIL tmo_hold cyc=%0d got=%b want=0100", c, gnt); end
            total++;
            if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_early cyc=%0d got=%b want=0", c, tmo_err); end
        end
        tick();
        req = 4'b0000;
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL tmo_release got=%b want=0000", gnt); end
        total++;
        if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b want=1", tmo_err); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky i=%0d got=%b want=1", i, tmo_err); end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", tmo_err); end
        // Clear requested in the same cycle as a new timeout: the set wins.
        req = 4'b1000;
        for (int c = 1; c <= 8; c++) tick();
        err_clr = 1'b1;
        tick();
        total++;
        if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_set_wins got=%b want=1", tmo_err); end
        req = 4'b0000;
        tick();
        err_clr = 1'b0;
        total++;
        if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_clear2 got=%b want=0", tmo_err); end
    endtask

    task automatic test_same_cycle;
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 8; c++) tick();
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL same_pre got=%b want=0100", gnt); end
        done = 4'b0100;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL same_release got=%b want=0000", gnt); end
        total++;
        if (tmo_err !== 1'b0) begin bad++; $display("FAIL same_tmo got=%b want=0", tmo_err); end
        tick();
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL midrst_pre got=%b want=0010", gnt); end
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_clear got=%b/%b want=0000/0", gnt, busy);
        end
        total++;
        if (owner !== 2'd0) begin bad++; $display("FAIL midrst_owner got=%0d want=0", owner); end
        rst = 1'b0;
        req = 4'b0011;
        tick();
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL midrst_next got=%b want=0001", gnt); end
    endtask

    task automatic test_nonowner_done;
        do_reset();
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL nod_grant got=%b want=0010", gnt); end
        done = 4'b1000;
        req  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0010) begin bad++; $display("FAIL nod_hold i=%0d got=%b want=0010", i, gnt); end
        end
        done = 4'b1101;
        tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL nod_multi got=%b want=0010", gnt); end
        done = 4'b0010;
        tick();
        done = 4'b0000;
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL nod_release got=%b want=0000", gnt); end
        tick();
        tick();
        total++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            bad++; $display("FAIL nod_next got=%b/%0d want=0100/2", gnt, owner);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            req     = 4'($urandom_range(0, 15));
            done    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            err_clr = ($urandom_range(0, 31) == 0);
            tick();
            total++;
            if ((gnt & (gnt - 4'd1)) !== 4'b0000) begin
                bad++; $display("FAIL rand_onehot i=%0d got=%b", i, gnt);
            end
            total++;
            if (busy !== (gnt != 4'b0000)) begin
                bad++; $display("FAIL rand_busy i=%0d got=%b gnt=%b", i, busy, gnt);
            end
            if (busy === 1'b1) begin
                total++;
                if (gnt !== (4'b0001 << owner)) begin
                    bad++; $display("FAIL rand_owner i=%0d gnt=%b owner=%0d", i, gnt, owner);
                end
            end
        end
        req = '0; done = '0; err_clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; req = '0; done = '0; err_clr = 1'b0;
        test_reset();
        test_dropped_req();
        test_single();
        test_round_robin();
        test_timeout();
        test_same_cycle();
        test_mid_reset();
        test_nonowner_done();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8; maximum number of cycles one owner may hold the bus, range 1..15.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  4  per-requester bus request; bit 0 = instruction controller, 1 = IN port, 2 = OUT port, 3 = loader.
REQ-005 done  in  4  per-requester release pulse; only the current owner's bit has effect.
REQ-006 err_clr  in  1  clears the sticky timeout flag.
REQ-007 gnt  out  4  one-hot bus grant, registered; all-zero when no owner.
REQ-008 owner  out  2  index of the current grant holder; value is valid only while busy=1.
REQ-009 busy  out  1  high while any gnt bit is high.
REQ-010 tmo_err  out  1  sticky flag; set when an owner is forcibly released by timeout.

Function
REQ-011 The block SHALL use a registered FSM with states IDLE, OWN and TURN; all outputs are registers.
REQ-012 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0.
REQ-013 In IDLE with req!=0, the FSM SHALL pick the winner round-robin, searching from pointer ptr upward modulo 4, and enter OWN.
REQ-014 On entry to OWN, the block SHALL assert gnt[winner] and busy and load owner; gnt rises exactly 1 cycle after the req sample edge.
REQ-015 A req bit dropped before the IDLE sample edge SHALL NOT be granted.
REQ-016 In OWN, a 4-bit hold counter SHALL start at 1 on the grant cycle and increment each cycle.
REQ-017 OWN SHALL exit to TURN on the first edge where any of these holds:
- done[owner]=1
- req[owner]=0
- hold counter == HOLD_MAX
REQ-018 done or req-drop and timeout in the same cycle SHALL be treated as a normal release; tmo_err is not set.
REQ-019 A timeout-only exit SHALL set tmo_err.
REQ-020 done bits of non-owners SHALL be ignored at all times.
REQ-021 Requests from other requesters during OWN SHALL NOT preempt the owner.
REQ-022 On entering TURN, the block SHALL clear gnt and busy, and set ptr = owner+1 (2-bit wrap, 3 -> 0).
REQ-023 TURN SHALL last exactly 1 cycle with gnt=0 (bus turnaround), then go to IDLE.
REQ-024 The minimum gap between the falling edge of one grant and the rising edge of the next SHALL be 2 cycles (TURN, then the IDLE sample).
REQ-025 A requester holding req continuously SHALL be re-granted only after every other active requester has been served once.
REQ-026 gnt SHALL never have more than one bit set.
REQ-027 err_clr SHALL clear tmo_err on the next edge; if a set event occurs in the same cycle, set wins.
REQ-028 owner SHALL retain its last value outside OWN.

Reset
REQ-029 With rst=1 at an edge, the block SHALL go to IDLE and reset: gnt=0, busy=0, owner=0, tmo_err=0, ptr=0, hold counter=0.
REQ-030 rst SHALL take priority over all other inputs, including mid-OWN; gnt falls on the same edge.
REQ-031 After rst is released, the first arbitration SHALL favour requester 0.

Verification
REQ-032 Single request: rst, then req=0001 held, done[0] pulsed at the 3rd grant cycle -> gnt=0001 from cycle 1 to cycle 3, TURN gnt=0000 one cycle, then gnt=0001 again.
REQ-033 Round-robin: req=1111 held, each owner pulses done on its first grant cycle -> grant order 0,1,2,3,0 with one idle cycle and one sample cycle between grants.
REQ-034 Timeout: HOLD_MAX=8, req=0100 held, no done -> gnt=0100 for exactly 8 cycles; tmo_err=1 after release and stays 1 until err_clr pulse.
REQ-035 Same-cycle done and timeout: owner pulses done on its 8th cycle -> release with tmo_err=0.
REQ-036 Mid-OWN reset: gnt=0010, rst pulsed -> gnt=0000 and busy=0 on that edge; next grant with req=0011 goes to requester 0.
REQ-037 Non-owner done and one-hot check: done=1000 while requester 1 owns -> no release; random req/done for 10k cycles -> gnt one-hot or zero, never two bits set.
